dbus_responder: RTL and testbench
=================================

DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, number of wait cycles between request acceptance and response; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 512, number of 64-bit storage words; power of two.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port dreq  input  dbus_req_t  data-bus request: valid, addr, size, strobe, data.
REQ-006 SHALL have port dresp  output  dbus_resp_t  data-bus response: addr_ok, data_ok, data.

Function
REQ-007 SHALL implement FSM with states IDLE, BUSY, RESP; reset state IDLE.
REQ-008 SHALL, in IDLE with dreq.valid=1 at a rising edge, latch addr, size, strobe and data, load the wait counter with LATENCY-1, and enter BUSY.
REQ-009 SHALL, in BUSY, decrement the wait counter each edge while dreq.valid=1; at the edge where the counter is 0, perform the access and enter RESP.
REQ-010 SHALL, in BUSY with dreq.valid=0 at an edge, abort: no write, no response, return to IDLE.
REQ-011 SHALL, in RESP, drive dresp.addr_ok=1 and dresp.data_ok=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-012 SHALL therefore produce data_ok in cycle T+LATENCY+1, where T is the first cycle valid is seen in IDLE.
REQ-013 SHALL leave at least one IDLE cycle between consecutive responses; back-to-back requests are accepted from that IDLE cycle.
REQ-014 SHALL index storage with latched addr[3+log2(DEPTH_WORDS)-1:3]; addr[2:0] and higher bits are ignored (addresses wrap modulo DEPTH_WORDS*8).
REQ-015 SHALL treat strobe != 0 as a write: byte i of the stored word is replaced by data byte i iff strobe[i]=1; other bytes are unchanged.
REQ-016 SHALL treat strobe = 0 as a read: dresp.data in RESP is the full 64-bit stored word; byte selection and sign extension remain the requester's job.
REQ-017 SHALL drive dresp.data with the post-merge stored word for writes.
REQ-018 SHALL drive dresp.addr_ok=0, dresp.data_ok=0 and dresp.data=0 in every state other than RESP.
REQ-019 SHALL ignore dreq.size functionally; strobe alone determines written bytes.
REQ-020 SHALL ignore changes to dreq fields after acceptance, except valid (abort per REQ-010).
REQ-021 SHALL register all dresp fields; no combinational path from dreq to dresp.

Reset
REQ-022 SHALL, on reset assertion at any time including mid-BUSY, go to IDLE immediately, clear the wait counter, latched request and dresp to 0, and suppress any pending write.
REQ-023 SHALL NOT clear storage contents on reset; contents are undefined until written.
REQ-024 SHALL accept a new request on the first edge after reset deasserts.

Structure
REQ-025 SHALL take dbus_req_t, dbus_resp_t, word_t and strobe_t from the shared common package; no new package types.
REQ-026 SHALL keep a responder FSM state enum local to the module.
REQ-027 SHALL place storage in one sub-module dbus_ram (synchronous write with 8-bit byte enables, read port) instantiated once.

Verification
REQ-028 Write addr=0x10, strobe=0xFF, data=0x1122334455667788, LATENCY=2 -> data_ok pulses exactly in cycle T+3 for one cycle; then read 0x10 returns 0x1122334455667788.
REQ-029 Write addr=0x13, strobe=0x08, data=0x00000000AA000000 over word 0x1122334455667788 at 0x10 -> subsequent read of 0x10 returns 0x11223344AA667788.
REQ-030 Read with valid dropped in the first BUSY cycle -> no data_ok; preceding write at the same address is intact on re-read.
REQ-031 Reset pulsed mid-BUSY of a write to 0x20 (strobe 0xFF, data 0xDEAD) -> outputs 0 immediately, no data_ok, read of 0x20 does not return 0xDEAD.
REQ-032 DEPTH_WORDS=512: write 0x1000 with data 0x5A, read 0x0 -> returns 0x5A (wrap-around).
REQ-033 Two back-to-back reads with valid held high -> second data_ok occurs exactly LATENCY+2 cycles after the first.

Source files
------------

// File: rtl/dbus_responder_pkg.sv
// Shared data-bus types for the responder slice.
// Provides the request/response structs, the storage word and strobe types,
// and a byte-merge helper used when a partial write lands on a stored word.
package dbus_responder_pkg;

  typedef logic [63:0] word_t;
  typedef logic [7:0]  strobe_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    strobe_t     strobe;
    word_t       data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  // Replace byte i of old_w with byte i of new_w wherever be[i] is set.
  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input strobe_t be);
    word_t res;
    res = old_w;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dbus_responder_ram.sv
// dbus_ram: word-organised storage for the responder.
// Ports:
//   clk_i   - clock; writes take effect on its rising edge
//   we_i    - write enable
//   be_i    - per-byte write enables
//   addr_i  - word index (shared by the write and read port)
//   wdata_i - write data
//   rdata_o - asynchronous read data of the word at addr_i
// Contents are not reset.
module dbus_ram
  import dbus_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 512
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  strobe_t                        be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  word_t                          wdata_i,
  output word_t                          rdata_o
);

  word_t mem_q [DEPTH_WORDS];

  // Byte-enabled synchronous write.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 8; i++) begin
      if (we_i && be_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_responder.sv
// dbus_responder: fixed-latency data-bus slave backed by a dbus_ram.
// A request seen in IDLE is latched, held for LATENCY cycles in BUSY (valid
// must stay high or the access is abandoned), performed on the final BUSY
// edge, and answered by a one-cycle addr_ok/data_ok pulse in RESP.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset
//   dreq  - request (valid, addr, size, strobe, data); size is not used
//   dresp - registered response (addr_ok, data_ok, data); all zero outside RESP
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 512
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  strobe_t     strobe_q, strobe_d;
  word_t       data_q, data_d;
  dbus_resp_t  dresp_q, dresp_d;

  logic          access_s;
  logic          ram_we_s;
  logic [AW-1:0] idx_s;
  word_t         rdata_s;
  word_t         merged_s;
  logic          unused_s;

  // Word index ignores the byte offset and everything above the array size,
  // so addresses wrap modulo DEPTH_WORDS*8.
  assign idx_s    = addr_q[3 +: AW];
  // A read (strobe 0) merges nothing, so this is the response word either way.
  assign merged_s = merge_bytes(rdata_s, data_q, strobe_q);
  // Gating with reset keeps an edge coincident with reset from writing.
  assign ram_we_s = access_s && (strobe_q != 8'h00) && !reset;
  assign unused_s = ^{dreq.size, addr_q[31:3+AW], addr_q[2:0]};

  // Next-state, request latching and response generation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    data_d   = data_q;
    dresp_d  = '0;
    access_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          addr_d   = dreq.addr;
          strobe_d = dreq.strobe;
          data_d   = dreq.data;
          cnt_d    = 4'(LATENCY - 1);
          state_d  = BUSY;
        end else begin
          state_d  = IDLE;
        end
      end
      BUSY: begin
        if (!dreq.valid) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          access_s        = 1'b1;
          dresp_d.addr_ok = 1'b1;
          dresp_d.data_ok = 1'b1;
          dresp_d.data    = merged_s;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and registered response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      strobe_q <= 8'h00;
      data_q   <= 64'd0;
      dresp_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      data_q   <= data_d;
      dresp_q  <= dresp_d;
    end
  end

  assign dresp = dresp_q;

  dbus_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we_s),
    .be_i   (strobe_q),
    .addr_i (idx_s),
    .wdata_i(data_q),
    .rdata_o(rdata_s)
  );

endmodule

// File: tb/tb_dbus_responder.sv
module tb_dbus_responder;
  import dbus_responder_pkg::*;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  int total = 0;
  int bad   = 0;
  int leak  = 0;

  always #5 clk = ~clk;

  dbus_responder #(.LATENCY(LAT), .DEPTH_WORDS(512)) dut (
    .clk  (clk),
    .reset(reset),
    .dreq (dreq),
    .dresp(dresp)
  );

  // Outside a response pulse every response field must read zero.
  always @(negedge clk) begin
    if ((dresp.addr_ok !== dresp.data_ok) ||
        (dresp.data_ok === 1'b0 && dresp.data !== 64'd0)) begin
      leak++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request; valid drops on the negedge where data_ok is seen.
  // first = negedge index (0 = acceptance cycle T) of the first data_ok.
  task automatic xfer(input logic [31:0] a, input strobe_t s, input word_t d,
                      output int first, output int pulses, output word_t rd);
    @(posedge clk); #1;
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = 3'($urandom_range(0, 7));
    dreq.strobe = s;
    dreq.data   = d;
    first  = -1;
    pulses = 0;
    rd     = 64'd0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = k;
          rd    = dresp.data;
        end
        dreq.valid = 1'b0;
      end
    end
  endtask

  initial begin
    int    f, p, f2;
    word_t rd, rd1;
    bit    seen;

    reset = 1'b1;
    dreq  = '0;
    repeat (2) @(negedge clk);
    chk("reset_flags", {62'd0, dresp.addr_ok, dresp.data_ok}, 64'd0);
    chk("reset_data", dresp.data, 64'd0);
    reset = 1'b0;

    // Full write, then read back.
    xfer(32'h10, 8'hFF, 64'h1122334455667788, f, p, rd);
    chk("wr_latency", 64'(f), 64'(LAT + 1));
    chk("wr_pulses", 64'(p), 64'd1);
    chk("wr_resp_data", rd, 64'h1122334455667788);
    xfer(32'h10, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, f, p, rd);
    chk("rd_latency", 64'(f), 64'(LAT + 1));
    chk("rd_data", rd, 64'h1122334455667788);

    // Single-byte write through an unaligned address.
    xfer(32'h13, 8'h08, 64'h00000000AA000000, f, p, rd);
    chk("part_resp_data", rd, 64'h11223344AA667788);
    xfer(32'h10, 8'h00, 64'd0, f, p, rd);
    chk("part_rd_data", rd, 64'h11223344AA667788);

    // Read aborted in its first BUSY cycle.
    @(posedge clk); #1;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h10;
    dreq.strobe = 8'h00;
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    p = 0;
    repeat (8) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1) p++;
    end
    chk("abort_no_resp", 64'(p), 64'd0);
    xfer(32'h10, 8'h00, 64'd0, f, p, rd);
    chk("abort_reread", rd, 64'h11223344AA667788);

    // Reset across the access edge of a write to 0x20.
    @(posedge clk); #1;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h20;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'h000000000000DEAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_busy_flags", {62'd0, dresp.addr_ok, dresp.data_ok}, 64'd0);
    p = 0;
    @(negedge clk);
    dreq.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1) p++;
    end
    chk("rst_no_resp", 64'(p), 64'd0);
    xfer(32'h20, 8'h00, 64'd0, f, p, rd);
    total++;
    assert (rd !== 64'h000000000000DEAD) else begin
      bad++;
      $error("FAIL rst_no_write: observed=%h expected=not %h", rd, 64'h000000000000DEAD);
    end
    chk("rst_then_accept", 64'(f), 64'(LAT + 1));

    // Reset during RESP clears the response at once.
    @(posedge clk); #1;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h10;
    dreq.strobe = 8'h00;
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1) seen = 1'b1;
    end
    chk("rresp_seen", 64'(seen), 64'd1);
    dreq.valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rresp_cleared_ok", {63'd0, dresp.data_ok}, 64'd0);
    chk("rresp_cleared_data", dresp.data, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Address wrap at 512 words.
    xfer(32'h1000, 8'hFF, 64'h5A, f, p, rd);
    xfer(32'h0, 8'h00, 64'd0, f, p, rd);
    chk("wrap_data", rd, 64'h5A);

    // Back-to-back reads with valid held high.
    @(posedge clk); #1;
    dreq.valid  = 1'b1;
    dreq.addr   = 32'h10;
    dreq.strobe = 8'h00;
    f   = -1;
    f2  = -1;
    rd1 = 64'd0;
    rd  = 64'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dresp.data_ok === 1'b1) begin
        if (f < 0) begin
          f   = k;
          rd1 = dresp.data;
        end else if (f2 < 0) begin
          f2 = k;
          rd = dresp.data;
          dreq.valid = 1'b0;
        end
      end
    end
    chk("b2b_first", 64'(f), 64'(LAT + 1));
    chk("b2b_gap", 64'(f2 - f), 64'(LAT + 2));
    chk("b2b_data1", rd1, 64'h11223344AA667788);
    chk("b2b_data2", rd, 64'h11223344AA667788);

    repeat (3) @(negedge clk);
    chk("idle_outputs_zero", 64'(leak), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
